// File: rtl/triangle_filler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : triangle_filler_pkg
// Brief    : Shared widths, FSM state encoding and vertex helpers for the
//            triangle rasterizer.
// Revision : 1.0 - initial release
// ============================================================================
package triangle_filler_pkg;

    localparam int c_coord_w = 16;
    localparam int c_vert_w  = 2 * c_coord_w;
    localparam int c_diff_w  = c_coord_w + 1;
    localparam int c_prod_w  = 2 * c_diff_w;
    localparam int c_edge_w  = c_prod_w + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SCAN  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Packed vertex layout is {x, y}: x in the upper half, y in the lower half.
    function automatic logic [c_coord_w-1:0] vert_x(input logic [c_vert_w-1:0] v);
        return v[c_vert_w-1:c_coord_w];
    endfunction

    function automatic logic [c_coord_w-1:0] vert_y(input logic [c_vert_w-1:0] v);
        return v[c_coord_w-1:0];
    endfunction

    function automatic logic [c_coord_w-1:0] min3(
        input logic [c_coord_w-1:0] a,
        input logic [c_coord_w-1:0] b,
        input logic [c_coord_w-1:0] c
    );
        logic [c_coord_w-1:0] m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    function automatic logic [c_coord_w-1:0] max3(
        input logic [c_coord_w-1:0] a,
        input logic [c_coord_w-1:0] b,
        input logic [c_coord_w-1:0] c
    );
        logic [c_coord_w-1:0] m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/triangle_filler_edge_eval.sv
`default_nettype none
// ============================================================================
// Module   : tri_edge_eval
// Brief    : Combinational edge function E_ab(p) = (bx-ax)(py-ay) - (by-ay)(px-ax).
// Revision : 1.0 - initial release
// ============================================================================
module tri_edge_eval
    import triangle_filler_pkg::*;
(
    input  logic [c_vert_w-1:0]         va,
    input  logic [c_vert_w-1:0]         vb,
    input  logic [c_coord_w-1:0]        px,
    input  logic [c_coord_w-1:0]        py,
    output logic signed [c_edge_w-1:0]  e
);

    logic signed [c_diff_w-1:0] w_dbx;
    logic signed [c_diff_w-1:0] w_dby;
    logic signed [c_diff_w-1:0] w_dpx;
    logic signed [c_diff_w-1:0] w_dpy;

    logic signed [c_prod_w-1:0] w_dbx_ext;
    logic signed [c_prod_w-1:0] w_dby_ext;
    logic signed [c_prod_w-1:0] w_dpx_ext;
    logic signed [c_prod_w-1:0] w_dpy_ext;

    logic signed [c_prod_w-1:0] w_prod_a;
    logic signed [c_prod_w-1:0] w_prod_b;

    assign w_dbx = $signed({1'b0, vert_x(vb)}) - $signed({1'b0, vert_x(va)});
    assign w_dby = $signed({1'b0, vert_y(vb)}) - $signed({1'b0, vert_y(va)});
    assign w_dpx = $signed({1'b0, px})         - $signed({1'b0, vert_x(va)});
    assign w_dpy = $signed({1'b0, py})         - $signed({1'b0, vert_y(va)});

    // Products of two 17-bit signed values always fit in 34 bits, so the
    // low half of a full-width multiply is exact.
    assign w_dbx_ext = {{(c_prod_w-c_diff_w){w_dbx[c_diff_w-1]}}, w_dbx};
    assign w_dby_ext = {{(c_prod_w-c_diff_w){w_dby[c_diff_w-1]}}, w_dby};
    assign w_dpx_ext = {{(c_prod_w-c_diff_w){w_dpx[c_diff_w-1]}}, w_dpx};
    assign w_dpy_ext = {{(c_prod_w-c_diff_w){w_dpy[c_diff_w-1]}}, w_dpy};

    assign w_prod_a = w_dbx_ext * w_dpy_ext;
    assign w_prod_b = w_dby_ext * w_dpx_ext;

    assign e = $signed({w_prod_a[c_prod_w-1], w_prod_a})
             - $signed({w_prod_b[c_prod_w-1], w_prod_b});

endmodule
`default_nettype wire

// File: rtl/triangle_filler.sv
`default_nettype none
// ============================================================================
// Module   : triangle_filler
// Brief    : Scans a triangle's bounding box in raster order and streams every
//            covered pixel over a valid/ready handshake, flagging done at the end.
// Revision : 1.0 - initial release
// ============================================================================
module triangle_filler
    import triangle_filler_pkg::*;
#(
    parameter int VERTEX_DATA_WIDTH = 32,
    parameter int PIXEL_ADDR_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         start,
    input  logic [VERTEX_DATA_WIDTH-1:0] v0,
    input  logic [VERTEX_DATA_WIDTH-1:0] v1,
    input  logic [VERTEX_DATA_WIDTH-1:0] v2,
    input  logic [VERTEX_DATA_WIDTH-1:0] v3,
    input  logic                         ready,
    output logic [PIXEL_ADDR_WIDTH-1:0]  x,
    output logic [PIXEL_ADDR_WIDTH-1:0]  y,
    output logic                         valid,
    output logic                         done
);

    state_t                r_state;
    logic [c_vert_w-1:0]   r_vert [3];
    logic [c_coord_w-1:0]  r_xmin;
    logic [c_coord_w-1:0]  r_xmax;
    logic [c_coord_w-1:0]  r_ymax;
    logic [c_coord_w-1:0]  r_cx;
    logic [c_coord_w-1:0]  r_cy;
    logic                  r_last;

    logic signed [c_edge_w-1:0] w_e [3];
    logic [2:0]            w_ge;
    logic [2:0]            w_le;
    logic                  w_inside;
    logic                  w_last_cand;
    logic                  w_row_end;
    logic                  w_advance;
    logic                  w_unused_v3;

    assign w_unused_v3 = ^v3;

    for (genvar gi = 0; gi < 3; gi++) begin : g_edge
        tri_edge_eval u_edge (
            .va (r_vert[gi]),
            .vb (r_vert[(gi + 1) % 3]),
            .px (r_cx),
            .py (r_cy),
            .e  (w_e[gi])
        );
        assign w_ge[gi] = ~w_e[gi][c_edge_w-1];
        assign w_le[gi] = w_e[gi][c_edge_w-1] | (w_e[gi] == '0);
    end

    // Accepting either sign makes coverage independent of vertex winding.
    assign w_inside    = (&w_ge) | (&w_le);
    assign w_row_end   = (r_cx == r_xmax);
    assign w_last_cand = w_row_end && (r_cy == r_ymax);
    assign w_advance   = !valid || ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= ST_IDLE;
            r_vert[0] <= '0;
            r_vert[1] <= '0;
            r_vert[2] <= '0;
            r_xmin    <= '0;
            r_xmax    <= '0;
            r_ymax    <= '0;
            r_cx      <= '0;
            r_cy      <= '0;
            r_last    <= 1'b0;
            x         <= '0;
            y         <= '0;
            valid     <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    valid <= 1'b0;
                    done  <= 1'b0;
                    if (start) begin
                        r_vert[0] <= v0[c_vert_w-1:0];
                        r_vert[1] <= v1[c_vert_w-1:0];
                        r_vert[2] <= v2[c_vert_w-1:0];
                        r_state   <= ST_SETUP;
                    end
                end

                ST_SETUP: begin
                    r_xmin  <= min3(vert_x(r_vert[0]), vert_x(r_vert[1]), vert_x(r_vert[2]));
                    r_xmax  <= max3(vert_x(r_vert[0]), vert_x(r_vert[1]), vert_x(r_vert[2]));
                    r_ymax  <= max3(vert_y(r_vert[0]), vert_y(r_vert[1]), vert_y(r_vert[2]));
                    r_cx    <= min3(vert_x(r_vert[0]), vert_x(r_vert[1]), vert_x(r_vert[2]));
                    r_cy    <= min3(vert_y(r_vert[0]), vert_y(r_vert[1]), vert_y(r_vert[2]));
                    r_last  <= 1'b0;
                    r_state <= ST_SCAN;
                end

                ST_SCAN: begin
                    if (w_advance) begin
                        if (r_last) begin
                            valid   <= 1'b0;
                            done    <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            valid <= w_inside;
                            x     <= PIXEL_ADDR_WIDTH'(r_cx);
                            y     <= PIXEL_ADDR_WIDTH'(r_cy);
                            // The cursor parks on the final candidate so it never wraps at 65535.
                            if (w_last_cand) begin
                                r_last <= 1'b1;
                            end else if (w_row_end) begin
                                r_cx <= r_xmin;
                                r_cy <= r_cy + c_coord_w'(1);
                            end else begin
                                r_cx <= r_cx + c_coord_w'(1);
                            end
                        end
                    end
                end

                ST_DONE: begin
                    valid <= 1'b0;
                    if (!start) begin
                        done    <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    valid   <= 1'b0;
                    done    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_triangle_filler.sv
`default_nettype none
// ============================================================================
// Module   : tb_triangle_filler
// Brief    : Directed self-checking bench for triangle_filler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_triangle_filler;

    typedef logic [31:0] pix_t;

    logic        clk;
    logic        resetn;
    logic        start;
    logic [31:0] v0;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [31:0] v3;
    logic        ready;
    logic [15:0] x;
    logic [15:0] y;
    logic        valid;
    logic        done;

    pix_t got_q[$];
    pix_t exp_q[$];
    pix_t ref_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   first_cyc;
    int   done_cyc;

    triangle_filler #(
        .VERTEX_DATA_WIDTH (32),
        .PIXEL_ADDR_WIDTH  (16)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .v0     (v0),
        .v1     (v1),
        .v2     (v2),
        .v3     (v3),
        .ready  (ready),
        .x      (x),
        .y      (y),
        .valid  (valid),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic pix_t pk(input int px, input int py);
        return {px[15:0], py[15:0]};
    endfunction

    function automatic pix_t got_at(input int i);
        if (i >= 0 && i < got_q.size()) return got_q[i];
        return 32'hFFFF_FFFF;
    endfunction

    function automatic longint edge_fn(input int ax, input int ay, input int bx,
                                       input int by, input int px, input int py);
        return longint'(bx - ax) * longint'(py - ay) - longint'(by - ay) * longint'(px - ax);
    endfunction

    // Reference rasterizer: direct edge functions over the bounding box.
    task automatic build_model(input pix_t a, input pix_t b, input pix_t c);
        int ax, ay, bx, by, cx, cy, xmin, xmax, ymin, ymax;
        longint e0, e1, e2;
        ax = int'(a[31:16]); ay = int'(a[15:0]);
        bx = int'(b[31:16]); by = int'(b[15:0]);
        cx = int'(c[31:16]); cy = int'(c[15:0]);
        xmin = (ax < bx) ? ax : bx; xmin = (xmin < cx) ? xmin : cx;
        xmax = (ax > bx) ? ax : bx; xmax = (xmax > cx) ? xmax : cx;
        ymin = (ay < by) ? ay : by; ymin = (ymin < cy) ? ymin : cy;
        ymax = (ay > by) ? ay : by; ymax = (ymax > cy) ? ymax : cy;
        exp_q.delete();
        for (int py = ymin; py <= ymax; py++) begin
            for (int px = xmin; px <= xmax; px++) begin
                e0 = edge_fn(ax, ay, bx, by, px, py);
                e1 = edge_fn(bx, by, cx, cy, px, py);
                e2 = edge_fn(cx, cy, ax, ay, px, py);
                if ((e0 >= 0 && e1 >= 0 && e2 >= 0) || (e0 <= 0 && e1 <= 0 && e2 <= 0))
                    exp_q.push_back(pk(px, py));
            end
        end
    endtask

    task automatic compare_q(input string tag, input pix_t want[$]);
        check({tag, " count"}, got_q.size(), want.size());
        for (int i = 0; i < got_q.size() && i < want.size(); i++) begin
            check({tag, " pixel"}, got_q[i], want[i]);
            if (got_q[i] != want[i]) break;
        end
    endtask

    // Issues one triangle, collects transfers at each negedge, checks stall stability.
    task automatic run_tri(input string tag, input pix_t a, input pix_t b, input pix_t c,
                           input bit rnd, input bit hold);
        int          cyc;
        bit          stalled;
        logic [15:0] sx, sy;
        got_q.delete();
        first_cyc = -1;
        stalled   = 1'b0;
        sx        = '0;
        sy        = '0;
        @(negedge clk);
        v0 = a; v1 = b; v2 = c; start = 1'b1; ready = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        v0 = 32'hDEAD_BEEF; v1 = 32'h0BAD_F00D; v2 = 32'h1234_5678;
        cyc = 0;
        while (!done && cyc < 40000) begin
            if (stalled) begin
                check({tag, " stall_x"}, x, sx);
                check({tag, " stall_y"}, y, sy);
                check({tag, " stall_valid"}, valid, 1'b1);
            end
            ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (valid && first_cyc < 0) first_cyc = cyc;
            if (valid && ready) got_q.push_back({x, y});
            stalled = valid && !ready;
            sx = x;
            sy = y;
            @(negedge clk);
            cyc++;
        end
        done_cyc = cyc;
        check({tag, " done_seen"}, done, 1'b1);
        check({tag, " done_valid_excl"}, valid, 1'b0);
        if (!hold) begin
            @(negedge clk);
            check({tag, " back_idle"}, done, 1'b0);
        end
    endtask

    initial begin
        resetn = 1'b0;
        start  = 1'b0;
        ready  = 1'b0;
        v0 = '0; v1 = '0; v2 = '0; v3 = 32'hA5A5_5A5A;
        repeat (2) @(negedge clk);
        check("reset x", x, 16'd0);
        check("reset y", y, 16'd0);
        check("reset valid", valid, 1'b0);
        check("reset done", done, 1'b0);
        resetn = 1'b1;

        // Right triangle: 15 pixels, 25 candidates.
        run_tri("t1", pk(1, 1), pk(5, 1), pk(1, 5), 1'b0, 1'b0);
        check("t1 count", got_q.size(), 15);
        check("t1 first", got_at(0), pk(1, 1));
        check("t1 last", got_at(got_q.size() - 1), pk(1, 5));
        check("t1 latency", first_cyc, 2);
        check("t1 done_cycle", done_cyc, 27);
        build_model(pk(1, 1), pk(5, 1), pk(1, 5));
        compare_q("t1 model", exp_q);

        // Lower triangle in both windings.
        run_tri("t2f", pk(1, 1), pk(5, 5), pk(1, 5), 1'b0, 1'b0);
        check("t2f count", got_q.size(), 15);
        check("t2f first", got_at(0), pk(1, 1));
        check("t2f last", got_at(got_q.size() - 1), pk(5, 5));
        check("t2f row3_end", got_at(5), pk(3, 3));
        ref_q = got_q;
        run_tri("t2r", pk(1, 5), pk(5, 5), pk(1, 1), 1'b0, 1'b0);
        compare_q("t2r vs fwd", ref_q);
        build_model(pk(1, 1), pk(5, 5), pk(1, 5));
        compare_q("t2r model", exp_q);

        // Collinear vertices.
        run_tri("t3", pk(1, 1), pk(5, 1), pk(3, 1), 1'b0, 1'b0);
        check("t3 count", got_q.size(), 5);
        check("t3 first", got_at(0), pk(1, 1));
        check("t3 last", got_at(4), pk(5, 1));

        // Single point.
        run_tri("t4", pk(7, 7), pk(7, 7), pk(7, 7), 1'b0, 1'b0);
        check("t4 count", got_q.size(), 1);
        check("t4 pixel", got_at(0), pk(7, 7));

        // Full-range corner: cursor must not wrap at 65535.
        run_tri("t5", pk(65534, 65534), pk(65535, 65534), pk(65534, 65535), 1'b0, 1'b0);
        check("t5 count", got_q.size(), 3);
        check("t5 last", got_at(2), pk(65534, 65535));

        // Backpressure: reference run, then random ready with start held high.
        run_tri("bp ref", pk(45, 1), pk(126, 59), pk(16, 41), 1'b0, 1'b0);
        build_model(pk(45, 1), pk(126, 59), pk(16, 41));
        compare_q("bp ref model", exp_q);
        ref_q = got_q;
        run_tri("bp rnd", pk(45, 1), pk(126, 59), pk(16, 41), 1'b1, 1'b1);
        compare_q("bp rnd vs ref", ref_q);
        repeat (3) begin
            @(negedge clk);
            check("hold done", done, 1'b1);
            check("hold valid", valid, 1'b0);
        end
        start = 1'b0;
        @(negedge clk);
        check("drop start idle", done, 1'b0);
        @(negedge clk);
        check("idle no valid", valid, 1'b0);

        // Reset in the middle of a scan.
        @(negedge clk);
        v0 = pk(1, 1); v1 = pk(5, 1); v2 = pk(1, 5); start = 1'b1; ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("mid scan valid", valid, 1'b1);
        resetn = 1'b0;
        #1;
        check("rst valid", valid, 1'b0);
        check("rst done", done, 1'b0);
        @(negedge clk);
        resetn = 1'b1;
        run_tri("post rst", pk(1, 1), pk(5, 5), pk(1, 5), 1'b0, 1'b0);
        build_model(pk(1, 1), pk(5, 5), pk(1, 5));
        compare_q("post rst model", exp_q);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
